xconnect_reduce_collector: RTL
==============================

Name: xconnect_reduce_collector

Overview:
- Sits directly downstream of the crossbar interconnect. Each cycle it receives one routed word per PE lane, plus that word's source PE index (src_connectivity).
- Over one collection sweep it accumulates, per lane, the sum of the words from each distinct source PE. A source already seen in the sweep is skipped, so repeats are not counted twice.
- At the end of the sweep it presents one reduced value per lane, with a per-lane group-count check, through a valid/ready result handshake.

Parameters:
- WORD_SIZE, 256, width of one PE data word.
- NOF_PES, 16, number of PE lanes (power of 2, at least 2).
- NOF_LEVELS, $clog2(NOF_PES), width of a source index.
- GROUP_SIZE_WIDTH, NOF_LEVELS+1, width of one group-size field.
- ACC_WIDTH, WORD_SIZE+NOF_LEVELS, width of each lane's sum; it cannot overflow for NOF_PES addends.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse that begins a sweep.
- busy  out  1  high while in COLLECT.
- in_valid  in  1  the current beat of in_pes_data/src_connectivity is valid.
- in_pes_data  in  WORD_SIZE*NOF_PES  routed words; lane j is at [WORD_SIZE*j +: WORD_SIZE].
- src_connectivity  in  NOF_LEVELS*NOF_PES  source PE index of lane j's word; lane j is at [NOF_LEVELS*j +: NOF_LEVELS].
- groups_sizes  in  GROUP_SIZE_WIDTH*NOF_PES  expected number of distinct sources per lane; sampled on start.
- result_valid  out  1  result is available; held until accepted.
- result_ready  in  1  consumer accepts the result.
- result_data  out  ACC_WIDTH*NOF_PES  per-lane sums; lane j is at [ACC_WIDTH*j +: ACC_WIDTH].
- result_err  out  NOF_PES  bit j is set when lane j's distinct-source count differs from its group size.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy=0, result_valid=0, result_data=0, result_err=0.
  - All seen masks, counts, accumulators and the beat counter are cleared.
  - Reset mid-sweep or mid-handshake discards all work; no result is produced.
- State IDLE:
  - start=1 moves to COLLECT next cycle.
  - On that same edge: accumulators=0, seen[j]=0 (NOF_PES bits per lane), cnt[j]=0, beat=0, and the group size for each lane is latched from groups_sizes.
  - in_valid is ignored in IDLE.
- State COLLECT (busy=1):
  - On each cycle with in_valid=1, for every lane j, with s = src_connectivity field j:
    - If seen[j][s]=0: acc[j] += zero-extended data j, seen[j][s] is set, and cnt[j] increments.
    - Otherwise lane j is unchanged.
  - Every accepted beat increments beat (a NOF_LEVELS+1 bit counter).
  - Cycles with in_valid=0 change nothing.
  - start is ignored in COLLECT.
  - The beat that brings beat to NOF_PES is processed normally. On the same edge the FSM goes to DONE, and the following are registered:
    - result_data = the final accumulators, including that last beat.
    - result_err[j] = (cnt_final[j] != latched group size j).
    - result_valid = 1.
  - Latency: result_valid rises one cycle after the NOF_PES-th valid beat is sampled.
- State DONE:
  - result_valid=1; result_data and result_err are held stable.
  - If result_valid && result_ready, the handshake completes that cycle and the FSM goes to IDLE, with result_valid=0 next cycle.
  - If start=1 in the same cycle as the handshake, the FSM goes directly to COLLECT with the same clearing and latching as from IDLE, and busy=1 next cycle.
  - start without result_ready is ignored. in_valid is ignored.
  - result_data and result_err keep their values after the handshake until the next sweep's completion overwrites them.
- Arithmetic:
  - Sums are unsigned and zero-extended to ACC_WIDTH; no wrap is possible.
  - A group-size field of 0 or greater than NOF_PES is legal input and simply forces result_err for that lane (cnt ranges 1..NOF_PES).
- Duplicate source within a sweep: skipped silently and not flagged as an error; this is the normal case for groups smaller than NOF_PES.
- Implementation: per-lane accumulators, seen masks and counts; single 3-state FSM.

Test Plan:
- NOF_PES=4, WORD_SIZE=8; all group sizes=4. Four beats: lane j receives src (j+k)%4 on beat k, and the word value equals 10*(src+1). -> After the 4th beat, result_valid=1 one cycle later, every lane=100, result_err=0.
- Group sizes=2 (pairs {0,1},{2,3}). Sources alternate within each pair over 4 beats with data 5/7 (lanes 0,1) and 9/11 (lanes 2,3). -> Sums are 12 for lanes 0,1 and 20 for lanes 2,3; duplicates are dropped; result_err=0.
- Group sizes=4 but lane 2 receives src 1 on all beats, data 3. -> result_data lane 2=3, result_err=4'b0100.
- in_valid gaps: beats arrive on cycles 1,3,4,7 with in_valid low between them. -> Sums match the gap-free case; result_valid rises at cycle 8; busy is high from cycle 1 through 7.
- Hold result_ready=0 for 5 cycles, pulse start meanwhile, then assert result_ready together with start. -> Result is held stable; the early start is ignored; the handshake cycle enters COLLECT with cleared accumulators.
- Assert rst on the 2nd beat of a sweep, then start a fresh sweep. -> Outputs are all 0 after reset; the new sweep's sums contain no residue from the aborted beats.

Source files
------------

// File: rtl/xconnect_reduce_collector.sv
// xconnect_reduce_collector: per-lane sum of distinct-source crossbar words over one sweep
module xconnect_reduce_collector #(
    parameter int WORD_SIZE        = 256,
    parameter int NOF_PES          = 16,
    parameter int NOF_LEVELS       = $clog2(NOF_PES),
    parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int ACC_WIDTH        = WORD_SIZE + NOF_LEVELS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    input  logic                                in_valid,
    input  logic [WORD_SIZE*NOF_PES-1:0]        in_pes_data,
    input  logic [NOF_LEVELS*NOF_PES-1:0]       src_connectivity,
    input  logic [GROUP_SIZE_WIDTH*NOF_PES-1:0] groups_sizes,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [ACC_WIDTH*NOF_PES-1:0]        result_data,
    output logic [NOF_PES-1:0]                  result_err
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    localparam logic [NOF_LEVELS:0] BEAT_LAST = NOF_PES;
    state_t                            state_q, state_d;
    logic [ACC_WIDTH-1:0]              acc_q [NOF_PES], acc_d [NOF_PES];
    logic [NOF_PES-1:0]                seen_q [NOF_PES], seen_d [NOF_PES];
    logic [GROUP_SIZE_WIDTH-1:0]       cnt_q [NOF_PES], cnt_d [NOF_PES];
    logic [GROUP_SIZE_WIDTH-1:0]       gsz_q [NOF_PES], gsz_d [NOF_PES];
    logic [NOF_LEVELS:0]               beat_q, beat_d;
    logic [ACC_WIDTH*NOF_PES-1:0]      res_data_q, res_data_d;
    logic [NOF_PES-1:0]                res_err_q, res_err_d;
    logic                              sweep_start;

    assign busy         = state_q == COLLECT;
    assign result_valid = state_q == DONE;
    assign result_data  = res_data_q;
    assign result_err   = res_err_q;
    assign sweep_start  = start && (state_q == IDLE || (state_q == DONE && result_ready));

    // next state: sweep clearing, distinct-source accumulation, result capture on the last beat
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        seen_d     = seen_q;
        cnt_d      = cnt_q;
        gsz_d      = gsz_q;
        beat_d     = beat_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        if (sweep_start) begin
            state_d = COLLECT;
            beat_d  = '0;
            for (int j = 0; j < NOF_PES; j++) begin
                acc_d[j]  = '0;
                seen_d[j] = '0;
                cnt_d[j]  = '0;
                gsz_d[j]  = groups_sizes[GROUP_SIZE_WIDTH*j +: GROUP_SIZE_WIDTH];
            end
        end else if (state_q == DONE && result_ready) begin
            state_d = IDLE;
        end else if (state_q == COLLECT && in_valid) begin
            beat_d = beat_q + 1'b1;
            for (int j = 0; j < NOF_PES; j++) begin
                if (!seen_q[j][src_connectivity[NOF_LEVELS*j +: NOF_LEVELS]]) begin
                    acc_d[j] = acc_q[j] + {{NOF_LEVELS{1'b0}}, in_pes_data[WORD_SIZE*j +: WORD_SIZE]};
                    seen_d[j][src_connectivity[NOF_LEVELS*j +: NOF_LEVELS]] = 1'b1;
                    cnt_d[j] = cnt_q[j] + GROUP_SIZE_WIDTH'(1);
                end
            end
            if (beat_d == BEAT_LAST) begin
                state_d = DONE;
                for (int j = 0; j < NOF_PES; j++) begin
                    res_data_d[ACC_WIDTH*j +: ACC_WIDTH] = acc_d[j];
                    res_err_d[j] = cnt_d[j] != gsz_q[j];
                end
            end
        end
    end

    // state registers with synchronous reset that discards any sweep in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '{default: '0};
            seen_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            gsz_q      <= '{default: '0};
            beat_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            seen_q     <= seen_d;
            cnt_q      <= cnt_d;
            gsz_q      <= gsz_d;
            beat_q     <= beat_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end
endmodule
